// File: rtl/mips_multicycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcodes, funct
// codes, FSM states, ALU operation codes and datapath mux encodings.
package mips_multicycle_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JR    = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_A      = 2'd3;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    typedef enum logic [3:0] {
        S_IF, S_ID, S_MADDR, S_MRD, S_MWB, S_MWR, S_REX,
        S_RWB, S_IEX, S_IWB, S_BR, S_JMP, S_JAL, S_JR
    } state_t;

    // What the ALU is being used for in the current state.
    typedef enum logic [2:0] {
        CLS_NONE, CLS_ADD, CLS_SUB, CLS_RTYPE, CLS_IMM, CLS_IWB
    } alu_cls_t;

endpackage

// File: rtl/mips_multicycle_controller_alu_op_decoder.sv
// ALU operation / zero-extend / illegal-instruction decoder.
// Ports: cls (state class), opc, func in; alu_operation, zero_ext, illegal out.
module alu_op_decoder
    import mips_multicycle_controller_pkg::*;
#(
    parameter int HAS_EXT = 1
) (
    input  alu_cls_t   cls,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    output logic [2:0] alu_operation,
    output logic       zero_ext,
    output logic       illegal
);

    localparam logic EXT = (HAS_EXT != 0);

    logic [2:0] r_op;
    logic [2:0] i_op;
    logic       r_ok;
    logic       logic_imm;

    always_comb begin
        r_ok = 1'b1;
        r_op = ALU_ADD;
        case (func)
            F_AND:   r_op = ALU_AND;
            F_OR:    r_op = ALU_OR;
            F_ADD:   r_op = ALU_ADD;
            F_SUB:   r_op = ALU_SUB;
            F_SLT:   r_op = ALU_SLT;
            F_JR:    r_op = ALU_ADD;
            default: r_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_op      = ALU_ADD;
        logic_imm = 1'b0;
        case (opc)
            OP_SLTI: i_op = ALU_SLT;
            OP_ANDI: begin
                i_op      = ALU_AND;
                logic_imm = EXT;
            end
            OP_ORI: begin
                i_op      = ALU_OR;
                logic_imm = EXT;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opc)
            OP_RTYPE: illegal = !r_ok;
            OP_J, OP_JAL, OP_BEQ, OP_JR,
            OP_ADDI, OP_SLTI, OP_LW, OP_SW: illegal = 1'b0;
            OP_BNE, OP_ANDI, OP_ORI: illegal = !EXT;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_operation = ALU_AND;
        zero_ext      = 1'b0;
        case (cls)
            CLS_ADD:   alu_operation = ALU_ADD;
            CLS_SUB:   alu_operation = ALU_SUB;
            CLS_RTYPE: alu_operation = r_op;
            CLS_IMM: begin
                alu_operation = i_op;
                zero_ext      = logic_imm;
            end
            // Writeback keeps the immediate extension stable for the regfile.
            CLS_IWB:   zero_ext = logic_imm;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM with memory ready handshake and timeout.
// Ports: clk, rst, opc, func, zero, mem_ready in; datapath controls out.
module mips_multicycle_controller
    import mips_multicycle_controller_pkg::*;
#(
    parameter int HAS_EXT     = 1,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opc,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_operation,
    output logic [1:0] pc_source,
    output logic       zero_ext,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic TO_EN = (MEM_TIMEOUT != 0);
    localparam int   CW    = TO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t        state;
    state_t        nxt;
    alu_cls_t      cls;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          mem_state;
    logic          tmo;
    logic [2:0]    dec_op;
    logic          dec_ze;
    logic          dec_ill;

    assign mem_state = (state == S_IF) || (state == S_MRD) ||
                       (state == S_MWR);

    // Counter has already absorbed MEM_TIMEOUT waits; another is too many.
    assign tmo = TO_EN && mem_state && !mem_ready &&
                 (cnt == CW'(MEM_TIMEOUT));

    assign mem_err = err_q && !rst;

    always_comb begin
        case (state)
            S_IF, S_ID, S_MADDR: cls = CLS_ADD;
            S_REX:               cls = CLS_RTYPE;
            S_IEX:               cls = CLS_IMM;
            S_IWB:               cls = CLS_IWB;
            S_BR:                cls = CLS_SUB;
            default:             cls = CLS_NONE;
        endcase
    end

    alu_op_decoder #(
        .HAS_EXT(HAS_EXT)
    ) u_dec (
        .cls          (cls),
        .opc          (opc),
        .func         (func),
        .alu_operation(dec_op),
        .zero_ext     (dec_ze),
        .illegal      (dec_ill)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IF:    nxt = mem_ready ? S_ID : S_IF;
            S_ID: begin
                if (dec_ill) begin
                    nxt = S_IF;
                end else if (opc == OP_JR ||
                             (opc == OP_RTYPE && func == F_JR)) begin
                    nxt = S_JR;
                end else begin
                    case (opc)
                        OP_LW, OP_SW:   nxt = S_MADDR;
                        OP_RTYPE:       nxt = S_REX;
                        OP_ADDI, OP_SLTI,
                        OP_ANDI, OP_ORI: nxt = S_IEX;
                        OP_BEQ, OP_BNE: nxt = S_BR;
                        OP_J:           nxt = S_JMP;
                        OP_JAL:         nxt = S_JAL;
                        default:        nxt = S_IF;
                    endcase
                end
            end
            S_MADDR: nxt = (opc == OP_LW) ? S_MRD : S_MWR;
            S_MRD: begin
                if (mem_ready)  nxt = S_MWB;
                else if (tmo)   nxt = S_IF;
            end
            S_MWR: begin
                if (mem_ready || tmo) nxt = S_IF;
            end
            S_REX:   nxt = S_RWB;
            S_IEX:   nxt = S_IWB;
            S_MWB, S_RWB, S_IWB,
            S_BR, S_JMP, S_JAL, S_JR: nxt = S_IF;
            default: nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= nxt;
            if (tmo) err_q <= 1'b1;
            // Stays zero outside a pending access, so each entry starts fresh.
            if (TO_EN && mem_state && !mem_ready && !tmo)
                cnt <= cnt + CW'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = RDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_operation = ALU_AND;
        pc_source     = PCS_ALU;
        zero_ext      = 1'b0;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            alu_operation = dec_op;
            zero_ext      = dec_ze;
            unique case (state)
                S_IF: begin
                    mem_read  = !tmo;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_ID: begin
                    alu_src_b  = SRCB_IMM_SH;
                    illegal    = dec_ill;
                    instr_done = dec_ill;
                end
                S_MADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MRD: begin
                    iord     = 1'b1;
                    mem_read = !tmo;
                end
                S_MWB: begin
                    mem_to_reg = M2R_MDR;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MWR: begin
                    iord       = 1'b1;
                    mem_write  = !tmo;
                    instr_done = mem_ready;
                end
                S_REX: alu_src_a = 1'b1;
                S_RWB: begin
                    reg_dst    = RDST_RD;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_IEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_IWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    alu_src_a  = 1'b1;
                    pc_source  = PCS_ALUOUT;
                    pc_write   = (opc == OP_BNE) ? !zero : zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    pc_source  = PCS_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                // Regfile captures the already-incremented PC as $31.
                S_JAL: begin
                    reg_dst    = RDST_RA;
                    mem_to_reg = M2R_PC;
                    reg_write  = 1'b1;
                    pc_source  = PCS_JUMP;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_source  = PCS_A;
                    pc_write   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: vector table plus
// hand sequences for wait states, timeout, illegal decode and reset.
module tb_mips_multicycle_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ORI  = 6'b001101;
    localparam logic [5:0] ANDI = 6'b001100;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] JAL  = 6'b000011;
    localparam logic [5:0] JRO  = 6'b000110;
    localparam logic [5:0] FADD = 6'b100000;
    localparam logic [5:0] FSLT = 6'b101010;
    localparam logic [5:0] FJR  = 6'b001000;
    localparam logic [5:0] FBAD = 6'b000111;
    localparam logic [5:0] FN0  = 6'b000000;
    localparam logic [2:0] AAND = 3'b000;
    localparam logic [2:0] AOR  = 3'b001;
    localparam logic [2:0] AADD = 3'b010;
    localparam logic [2:0] ASUB = 3'b011;
    localparam logic [2:0] ASLT = 3'b111;
    localparam logic [2:0] A0   = 3'b000;
    localparam logic       H    = 1'b1;
    localparam logic       L    = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [5:0] opc = '0;
    logic [5:0] func = '0;

    logic       pc_write[2], iord[2], mem_read[2], mem_write[2];
    logic       ir_write[2], reg_write[2], alu_src_a[2], zero_ext[2];
    logic       instr_done[2], illegal[2], mem_err[2];
    logic [1:0] reg_dst[2], mem_to_reg[2], alu_src_b[2], pc_source[2];
    logic [2:0] alu_operation[2];
    logic [21:0] w[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_controller #(.HAS_EXT(1), .MEM_TIMEOUT(0)) d1 (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write[0]), .iord(iord[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]),
        .ir_write(ir_write[0]), .reg_dst(reg_dst[0]),
        .mem_to_reg(mem_to_reg[0]), .reg_write(reg_write[0]),
        .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
        .alu_operation(alu_operation[0]), .pc_source(pc_source[0]),
        .zero_ext(zero_ext[0]), .instr_done(instr_done[0]),
        .illegal(illegal[0]), .mem_err(mem_err[0])
    );

    mips_multicycle_controller #(.HAS_EXT(0), .MEM_TIMEOUT(2)) d2 (
        .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write[1]), .iord(iord[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]),
        .ir_write(ir_write[1]), .reg_dst(reg_dst[1]),
        .mem_to_reg(mem_to_reg[1]), .reg_write(reg_write[1]),
        .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
        .alu_operation(alu_operation[1]), .pc_source(pc_source[1]),
        .zero_ext(zero_ext[1]), .instr_done(instr_done[1]),
        .illegal(illegal[1]), .mem_err(mem_err[1])
    );

    for (genvar k = 0; k < 2; k++) begin : g_pack
        assign w[k] = {pc_write[k], iord[k], mem_read[k], mem_write[k],
                       ir_write[k], reg_dst[k], mem_to_reg[k],
                       reg_write[k], alu_src_a[k], alu_src_b[k],
                       alu_operation[k], pc_source[k], zero_ext[k],
                       instr_done[k], illegal[k], mem_err[k]};
    end

    typedef struct {
        string       name;
        logic        r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic [21:0] E_IF, E_IFW, E_ID, E_ILL, E_MADDR, E_MRD, E_MWB;
    logic [21:0] E_REXA, E_REXS, E_RWB, E_IEXO, E_IEXA, E_IWBZ;
    logic [21:0] E_BR1, E_BR0, E_JMP, E_JAL, E_JR;
    logic        mr_exp[6];
    logic        irw_seen;
    int          mw_n, rw_n, done_at;

    function automatic logic [21:0] o(
        input logic pcw, iord_, mr, mw, irw,
        input logic [1:0] rd, m2r,
        input logic rw, sa,
        input logic [1:0] sb,
        input logic [2:0] op,
        input logic [1:0] ps,
        input logic ze, dn, il, er
    );
        return {pcw, iord_, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps,
                ze, dn, il, er};
    endfunction

    task automatic add(input string n, input logic r,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy,
                       input logic [21:0] e);
        tbl.push_back('{n, r, op, fn, z, rdy, e});
    endtask

    task automatic cyc(input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic z,
                       input logic rdy);
        @(negedge clk);
        rst = r; opc = op; func = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    task automatic chk(input string n, input logic [21:0] got,
                       input logic [21:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic chk1(input string n, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, got, exp);
        end
    endtask

    task automatic chki(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, got, exp);
        end
    endtask

    initial begin
        //          pcw iord mr mw irw rd     m2r   rw sa sb     op    ps     ze dn il er
        E_IF   = o(H, L, H, L, H, 2'd0, 2'd0, L, L, 2'd1, AADD, 2'd0, L, L, L, L);
        E_IFW  = o(L, L, H, L, L, 2'd0, 2'd0, L, L, 2'd1, AADD, 2'd0, L, L, L, L);
        E_ID   = o(L, L, L, L, L, 2'd0, 2'd0, L, L, 2'd3, AADD, 2'd0, L, L, L, L);
        E_ILL  = o(L, L, L, L, L, 2'd0, 2'd0, L, L, 2'd3, AADD, 2'd0, L, H, H, L);
        E_MADDR= o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd2, AADD, 2'd0, L, L, L, L);
        E_MRD  = o(L, H, H, L, L, 2'd0, 2'd0, L, L, 2'd0, A0,   2'd0, L, L, L, L);
        E_MWB  = o(L, L, L, L, L, 2'd0, 2'd1, H, L, 2'd0, A0,   2'd0, L, H, L, L);
        E_REXA = o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd0, AADD, 2'd0, L, L, L, L);
        E_REXS = o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd0, ASLT, 2'd0, L, L, L, L);
        E_RWB  = o(L, L, L, L, L, 2'd1, 2'd0, H, L, 2'd0, A0,   2'd0, L, H, L, L);
        E_IEXO = o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd2, AOR,  2'd0, H, L, L, L);
        E_IEXA = o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd2, AAND, 2'd0, H, L, L, L);
        E_IWBZ = o(L, L, L, L, L, 2'd0, 2'd0, H, L, 2'd0, A0,   2'd0, H, H, L, L);
        E_BR1  = o(H, L, L, L, L, 2'd0, 2'd0, L, H, 2'd0, ASUB, 2'd1, L, H, L, L);
        E_BR0  = o(L, L, L, L, L, 2'd0, 2'd0, L, H, 2'd0, ASUB, 2'd1, L, H, L, L);
        E_JMP  = o(H, L, L, L, L, 2'd0, 2'd0, L, L, 2'd0, A0,   2'd2, L, H, L, L);
        E_JAL  = o(H, L, L, L, L, 2'd2, 2'd2, H, L, 2'd0, A0,   2'd2, L, H, L, L);
        E_JR   = o(H, L, L, L, L, 2'd0, 2'd0, L, L, 2'd0, A0,   2'd3, L, H, L, L);
        mr_exp = '{H, H, L, H, H, L};

        add("reset",     H, LW,  FN0, L, H, 22'd0);
        add("lw_if",     L, LW,  FN0, L, H, E_IF);
        add("lw_id",     L, LW,  FN0, L, H, E_ID);
        add("lw_maddr",  L, LW,  FN0, L, H, E_MADDR);
        add("lw_mrd",    L, LW,  FN0, L, H, E_MRD);
        add("lw_mwb",    L, LW,  FN0, L, H, E_MWB);
        add("beq1_if",   L, BEQ, FN0, H, H, E_IF);
        add("beq1_id",   L, BEQ, FN0, H, H, E_ID);
        add("beq1_br",   L, BEQ, FN0, H, H, E_BR1);
        add("beq0_if",   L, BEQ, FN0, L, H, E_IF);
        add("beq0_id",   L, BEQ, FN0, L, H, E_ID);
        add("beq0_br",   L, BEQ, FN0, L, H, E_BR0);
        add("bne1_if",   L, BNE, FN0, H, H, E_IF);
        add("bne1_id",   L, BNE, FN0, H, H, E_ID);
        add("bne1_br",   L, BNE, FN0, H, H, E_BR0);
        add("bne0_if",   L, BNE, FN0, L, H, E_IF);
        add("bne0_id",   L, BNE, FN0, L, H, E_ID);
        add("bne0_br",   L, BNE, FN0, L, H, E_BR1);
        add("add_if",    L, RT,  FADD, L, H, E_IF);
        add("add_id",    L, RT,  FADD, L, H, E_ID);
        add("add_rex",   L, RT,  FADD, L, H, E_REXA);
        add("add_rwb",   L, RT,  FADD, L, H, E_RWB);
        add("slt_if",    L, RT,  FSLT, L, H, E_IF);
        add("slt_id",    L, RT,  FSLT, L, H, E_ID);
        add("slt_rex",   L, RT,  FSLT, L, H, E_REXS);
        add("slt_rwb",   L, RT,  FSLT, L, H, E_RWB);
        add("ori_if",    L, ORI, FN0, L, H, E_IF);
        add("ori_id",    L, ORI, FN0, L, H, E_ID);
        add("ori_iex",   L, ORI, FN0, L, H, E_IEXO);
        add("ori_iwb",   L, ORI, FN0, L, H, E_IWBZ);
        add("j_if",      L, J,   FN0, L, H, E_IF);
        add("j_id",      L, J,   FN0, L, H, E_ID);
        add("j_jmp",     L, J,   FN0, L, H, E_JMP);
        add("jal_if",    L, JAL, FN0, L, H, E_IF);
        add("jal_id",    L, JAL, FN0, L, H, E_ID);
        add("jal_jal",   L, JAL, FN0, L, H, E_JAL);
        add("jr_if",     L, RT,  FJR, L, H, E_IF);
        add("jr_id",     L, RT,  FJR, L, H, E_ID);
        add("jr_jr",     L, RT,  FJR, L, H, E_JR);
        add("jro_if",    L, JRO, FN0, L, H, E_IF);
        add("jro_id",    L, JRO, FN0, L, H, E_ID);
        add("jro_jr",    L, JRO, FN0, L, H, E_JR);
        add("badf_if",   L, RT,  FBAD, L, H, E_IF);
        add("badf_id",   L, RT,  FBAD, L, H, E_ILL);
        add("badf_ret",  L, RT,  FBAD, L, L, E_IFW);

        foreach (tbl[i]) begin
            cyc(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy);
            chk(tbl[i].name, w[0], tbl[i].exp);
        end

        // sw with three wait cycles on the write.
        cyc(H, SW, FN0, L, H);
        mw_n = 0; rw_n = 0; done_at = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc(L, SW, FN0, L, !(c >= 4 && c <= 6));
            if (mem_write[0]) mw_n++;
            if (reg_write[0]) rw_n++;
            if (instr_done[0] && done_at == 0) done_at = c;
        end
        chki("sw_write_cycles", mw_n, 4);
        chki("sw_no_regwrite", rw_n, 0);
        chki("sw_done_cycle", done_at, 7);
        cyc(L, SW, FN0, L, H);
        chk("sw_back_if", w[0], E_IF);

        // Fetch timeout on the MEM_TIMEOUT=2 instance.
        cyc(H, RT, FN0, L, L);
        chk("d2_reset", w[1], 22'd0);
        irw_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(L, RT, FN0, L, L);
            chk1("to_mem_read", mem_read[1], mr_exp[c]);
            chk1("to_mem_err", mem_err[1], c >= 3);
            irw_seen = irw_seen | ir_write[1];
        end
        chk1("to_no_ir_write", irw_seen, 1'b0);
        cyc(H, ANDI, FN0, L, H);
        chk1("rst_clears_err", mem_err[1], 1'b0);
        chk("rst_outputs_d2", w[1], 22'd0);

        // andi: illegal without the extension, legal with it.
        cyc(L, ANDI, FN0, L, H);
        chk("ill_if", w[1], E_IF);
        cyc(L, ANDI, FN0, L, H);
        chk("ill_id", w[1], E_ILL);
        chk("andi_ext_id", w[0], E_ID);
        cyc(L, ANDI, FN0, L, L);
        chk("ill_back_if", w[1], E_IFW);
        chk("andi_iex", w[0], E_IEXA);

        // Reset in the middle of a stalled load.
        cyc(H, LW, FN0, L, H);
        cyc(L, LW, FN0, L, H);
        cyc(L, LW, FN0, L, H);
        cyc(L, LW, FN0, L, H);
        cyc(L, LW, FN0, L, L);
        chk("mrd_wait", w[0], E_MRD);
        cyc(H, LW, FN0, L, L);
        chk("rst_mid_mrd", w[0], 22'd0);
        cyc(H, LW, FN0, L, L);
        chk("rst_hold", w[0], 22'd0);
        cyc(L, LW, FN0, L, L);
        chk("first_fetch", w[0], E_IFW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
